aw_burst_splitter: RTL
======================

Name: aw_burst_splitter

Overview:
- Write-address-channel stage directly upstream of the write-response merging virtual master in the AXI4-to-AXI3 interconnect path.
- Accepts one AXI4 AW burst of up to 256 beats and reissues it downstream as AXI3 sub-bursts of at most 16 beats.
- Supplies the response merger with the split bookkeeping: load pulse, complete-burst count, remainder and split flag.
- Holds off the next AW acceptance until the merged B response for the current transaction has completed.

Parameters:
ADDR_WIDTH, 32, address width of both AW interfaces
AXI4_AW_LEN, 8, upstream awlen width
AXI3_AW_LEN, 4, downstream awlen width; max sub-burst = 2**AXI3_AW_LEN beats

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
s_awaddr  in  ADDR_WIDTH  upstream address
s_awlen  in  AXI4_AW_LEN  upstream beats-1
s_awsize  in  3  bytes/beat = 2**s_awsize
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_awvalid  in  1  upstream valid
s_awready  out  1  upstream ready
m_awaddr  out  ADDR_WIDTH  sub-burst address
m_awlen  out  AXI3_AW_LEN  sub-burst beats-1
m_awsize  out  3  copy of captured awsize
m_awburst  out  2  copy of captured awburst
m_awvalid  out  1  downstream valid
m_awready  in  1  downstream ready
load_original  out  1  one-cycle pulse: bookkeeping outputs updated
num_compl_bursts  out  AXI4_AW_LEN-AXI3_AW_LEN+1  (awlen+1) >> AXI3_AW_LEN
rem  out  AXI3_AW_LEN  (awlen+1) mod 2**AXI3_AW_LEN
trans_split  out  1  high while current transaction is split into >1 sub-burst
b_done  in  1  pulse: merged B handshake to the upstream master completed

Behaviour:
- Reset values: s_awready 0, m_awvalid 0, load_original 0, trans_split 0, num_compl_bursts 0, rem 0, m_awaddr/m_awlen/m_awsize/m_awburst 0, state IDLE.
- Reset is asynchronous. Assertion mid-operation abandons the transaction immediately; m_awvalid drops with reset.
- FSM states: IDLE, ISSUE, WAIT_B.
- IDLE:
  - s_awready = 1.
  - On s_awvalid & s_awready: capture all s_aw* fields, go to ISSUE.
  - Registered in the same edge: num_compl_bursts, rem, remaining-sub-burst counter = s_awlen[AXI4_AW_LEN-1:AXI3_AW_LEN] + 1, trans_split = (s_awlen > 2**AXI3_AW_LEN - 1).
  - load_original is high exactly the cycle after the handshake.
- ISSUE:
  - s_awready = 0; m_awvalid = 1, asserted first in the cycle after acceptance (1-cycle latency).
  - m_awlen = all-ones (15) for every non-final sub-burst; final sub-burst m_awlen = captured awlen[AXI3_AW_LEN-1:0].
  - On m_awvalid & m_awready, the next sub-burst is presented on the following cycle with m_awvalid held high (no bubble); counter decrements.
  - Address advance on each handshake:
    - INCR: m_awaddr += 2**AXI3_AW_LEN << awsize.
    - FIXED: address unchanged.
    - WRAP: at most 16 beats, so never split; passed through as a single sub-burst.
  - After the final sub-burst handshake, m_awvalid = 0 next cycle and go to WAIT_B.
- AXI stability: while m_awvalid & !m_awready, all m_aw* outputs are held constant.
- WAIT_B:
  - s_awready = 0, m_awvalid = 0. On b_done, go to IDLE; s_awready = 1 the next cycle.
  - b_done outside WAIT_B is ignored.
- Unsplit transaction (awlen ≤ 15): one sub-burst, trans_split = 0, bookkeeping still updated with load_original.
- num_compl_bursts, rem and trans_split hold their values until the next acceptance.
- 4KB crossing needs no handling: the original burst is legal and INCR sub-bursts stay inside it.
- Arithmetic:
  - Beat count is computed AXI4_AW_LEN+1 bits wide, so awlen = 255 gives num_compl_bursts = 16, rem = 0.
  - The address adder is ADDR_WIDTH wide and wraps modulo 2**ADDR_WIDTH.

Test Plan:
- INCR awlen=3, addr 0x1000, size 2 -> one m_aw: addr 0x1000, len 3; trans_split 0, num_compl_bursts 0, rem 4; load_original pulses 1 cycle after s handshake.
- INCR awlen=39, addr 0x2000, size 2, m_awready tied 1 -> back-to-back m_aw {0x2000,15}, {0x2040,15}, {0x2080,7}; num_compl_bursts 2, rem 8, trans_split 1.
- INCR awlen=255, addr 0x0, size 3 -> 16 sub-bursts of len 15 at 0x000, 0x080 … 0x780; num_compl_bursts 16, rem 0.
- awlen=39 with m_awready low 5 cycles at the second sub-burst -> m_awaddr 0x2040 and m_awlen 15 stable throughout; exactly 3 handshakes total.
- FIXED awlen=31, addr 0x3000 -> two sub-bursts, both addr 0x3000, len 15. New s_awvalid during WAIT_B stays un-accepted until b_done, then is accepted 1 cycle later.
- ARESETN low during second sub-burst of a split -> m_awvalid 0 and trans_split 0 immediately; after release s_awready 1 and a fresh awlen=3 transaction completes normally.

Source files
------------

// File: rtl/aw_burst_splitter.sv
// Splits one AXI4 AW burst (up to 256 beats) into AXI3 sub-bursts of at most
// 2**AXI3_AW_LEN beats and hands the split bookkeeping to the B-response merger.
module aw_burst_splitter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int AXI4_AW_LEN = 8,
  parameter int AXI3_AW_LEN = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [ADDR_WIDTH-1:0]              s_awaddr,
  input  logic [AXI4_AW_LEN-1:0]             s_awlen,
  input  logic [2:0]                         s_awsize,
  input  logic [1:0]                         s_awburst,
  input  logic                               s_awvalid,
  output logic                               s_awready,
  output logic [ADDR_WIDTH-1:0]              m_awaddr,
  output logic [AXI3_AW_LEN-1:0]             m_awlen,
  output logic [2:0]                         m_awsize,
  output logic [1:0]                         m_awburst,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  output logic                               load_original,
  output logic [AXI4_AW_LEN-AXI3_AW_LEN:0]   num_compl_bursts,
  output logic [AXI3_AW_LEN-1:0]             rem,
  output logic                               trans_split,
  input  logic                               b_done
);
  localparam int CW = AXI4_AW_LEN - AXI3_AW_LEN + 1;
  localparam logic [ADDR_WIDTH-1:0] SUB_BYTES = ADDR_WIDTH'(2**AXI3_AW_LEN);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B} state_t;

  state_t                  state_q, state_d;
  logic                    s_awready_q, s_awready_d;
  logic                    m_awvalid_q, m_awvalid_d;
  logic [ADDR_WIDTH-1:0]   m_awaddr_q, m_awaddr_d;
  logic [AXI3_AW_LEN-1:0]  m_awlen_q, m_awlen_d;
  logic [2:0]              m_awsize_q, m_awsize_d;
  logic [1:0]              m_awburst_q, m_awburst_d;
  logic                    load_original_q, load_original_d;
  logic [CW-1:0]           num_compl_q, num_compl_d;
  logic [AXI3_AW_LEN-1:0]  rem_q, rem_d;
  logic                    split_q, split_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AXI3_AW_LEN-1:0]  len_lo_q, len_lo_d;
  logic [AXI4_AW_LEN:0]    beats;
  logic                    accept, m_hs;

  // One bit wider than awlen so that 256 beats is representable.
  assign beats  = {1'b0, s_awlen} + (AXI4_AW_LEN+1)'(1);
  assign accept = (state_q == IDLE) && s_awvalid && s_awready_q;
  assign m_hs   = m_awvalid_q && m_awready;

  always_comb begin
    state_d         = state_q;
    m_awvalid_d     = m_awvalid_q;
    m_awaddr_d      = m_awaddr_q;
    m_awlen_d       = m_awlen_q;
    m_awsize_d      = m_awsize_q;
    m_awburst_d     = m_awburst_q;
    load_original_d = 1'b0;
    num_compl_d     = num_compl_q;
    rem_d           = rem_q;
    split_d         = split_q;
    cnt_d           = cnt_q;
    len_lo_d        = len_lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d         = ISSUE;
          m_awvalid_d     = 1'b1;
          m_awaddr_d      = s_awaddr;
          m_awsize_d      = s_awsize;
          m_awburst_d     = s_awburst;
          len_lo_d        = s_awlen[AXI3_AW_LEN-1:0];
          split_d         = |s_awlen[AXI4_AW_LEN-1:AXI3_AW_LEN];
          m_awlen_d       = split_d ? '1 : s_awlen[AXI3_AW_LEN-1:0];
          cnt_d           = {1'b0, s_awlen[AXI4_AW_LEN-1:AXI3_AW_LEN]} + CW'(1);
          num_compl_d     = beats[AXI4_AW_LEN:AXI3_AW_LEN];
          rem_d           = beats[AXI3_AW_LEN-1:0];
          load_original_d = 1'b1;
        end
      end
      ISSUE: begin
        if (m_hs) begin
          if (cnt_q == CW'(1)) begin
            m_awvalid_d = 1'b0;
            state_d     = WAIT_B;
          end else begin
            cnt_d = cnt_q - CW'(1);
            // FIXED keeps its address; WRAP never reaches here (<= 16 beats).
            if (m_awburst_q == BURST_INCR)
              m_awaddr_d = m_awaddr_q + (SUB_BYTES << m_awsize_q);
            m_awlen_d = (cnt_q == CW'(2)) ? len_lo_q : '1;
          end
        end
      end
      WAIT_B: begin
        if (b_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_awready_d = (state_d == IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q         <= IDLE;
      s_awready_q     <= 1'b0;
      m_awvalid_q     <= 1'b0;
      m_awaddr_q      <= '0;
      m_awlen_q       <= '0;
      m_awsize_q      <= '0;
      m_awburst_q     <= '0;
      load_original_q <= 1'b0;
      num_compl_q     <= '0;
      rem_q           <= '0;
      split_q         <= 1'b0;
      cnt_q           <= '0;
      len_lo_q        <= '0;
    end else begin
      state_q         <= state_d;
      s_awready_q     <= s_awready_d;
      m_awvalid_q     <= m_awvalid_d;
      m_awaddr_q      <= m_awaddr_d;
      m_awlen_q       <= m_awlen_d;
      m_awsize_q      <= m_awsize_d;
      m_awburst_q     <= m_awburst_d;
      load_original_q <= load_original_d;
      num_compl_q     <= num_compl_d;
      rem_q           <= rem_d;
      split_q         <= split_d;
      cnt_q           <= cnt_d;
      len_lo_q        <= len_lo_d;
    end
  end

  assign s_awready        = s_awready_q;
  assign m_awvalid        = m_awvalid_q;
  assign m_awaddr         = m_awaddr_q;
  assign m_awlen          = m_awlen_q;
  assign m_awsize         = m_awsize_q;
  assign m_awburst        = m_awburst_q;
  assign load_original    = load_original_q;
  assign num_compl_bursts = num_compl_q;
  assign rem              = rem_q;
  assign trans_split      = split_q;
endmodule
